ntt_stage_seq: RTL and testbench

NTT_STAGE_SEQ -- requirements
Module: ntt_stage_seq

---
 rtl/ntt_stage_seq_if.sv | 42 ++++
 rtl/ntt_stage_seq.sv | 170 +++++++++++++++++
 tb/tb_ntt_stage_seq.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_stage_seq_if.sv
// Control bus between the NTT stage sequencer and its datapath environment.
//   Environment -> sequencer : start, inv_mode, abort, agu_valid, rd_ack, ntt_done
//   Sequencer -> environment : tf_init_base, tf_init_const, tf_ren, agu_enable,
//                              r_enable, w_enable, ntt_enable, it_depth_cnt,
//                              bu_idx, busy, done
// The sequencer connects through the master modport and the environment through the slave modport.
interface ntt_stage_seq_if #(
    parameter int unsigned D_WIDTH = 8
);
    logic               start;
    logic               inv_mode;
    logic               abort;
    logic               agu_valid;
    logic               rd_ack;
    logic               ntt_done;

    logic               tf_init_base;
    logic               tf_init_const;
    logic               tf_ren;
    logic               agu_enable;
    logic               r_enable;
    logic               w_enable;
    logic               ntt_enable;
    logic [D_WIDTH-1:0] it_depth_cnt;
    logic [D_WIDTH-1:0] bu_idx;
    logic               busy;
    logic               done;

    // Sequencer side.
    modport master (
        input  start, inv_mode, abort, agu_valid, rd_ack, ntt_done,
        output tf_init_base, tf_init_const, tf_ren, agu_enable, r_enable,
               w_enable, ntt_enable, it_depth_cnt, bu_idx, busy, done
    );

    // Environment side.
    modport slave (
        output start, inv_mode, abort, agu_valid, rd_ack, ntt_done,
        input  tf_init_base, tf_init_const, tf_ren, agu_enable, r_enable,
               w_enable, ntt_enable, it_depth_cnt, bu_idx, busy, done
    );
endinterface

// File: rtl/ntt_stage_seq.sv
// NTT stage sequencer: twiddle init, then per stage a RUN phase issuing
// BU_PER_STAGE butterflies followed by a fixed pipeline DRAIN, then a
// one-cycle DONE pulse. Stages run ascending (forward) or descending (inverse).
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : control bus (master modport), see ntt_stage_seq_if
// Outputs are decoded combinationally from the registered state, the
// counters and the handshake inputs.
module ntt_stage_seq #(
    parameter int unsigned D_WIDTH      = 8,
    parameter int unsigned NUM_STAGES   = 3,
    parameter int unsigned BU_PER_STAGE = 16,
    parameter int unsigned INIT_CYCLES  = 4,
    parameter int unsigned DRAIN_CYCLES = 11
) (
    input  logic               clk,
    input  logic               rst,
    ntt_stage_seq_if.master    bus
);

    // Phase counter covers both INIT and DRAIN; widened if either phase is
    // longer than D_WIDTH can count so it never wraps.
    localparam int unsigned MAX_PHASE = (INIT_CYCLES > DRAIN_CYCLES) ? INIT_CYCLES : DRAIN_CYCLES;
    localparam int unsigned PH_BITS   = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam int unsigned CNT_W     = (PH_BITS > D_WIDTH) ? PH_BITS : D_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [D_WIDTH-1:0] STAGE_FIRST = D_WIDTH'(0);
    localparam logic [D_WIDTH-1:0] STAGE_LAST  = D_WIDTH'(NUM_STAGES - 1);
    localparam logic [D_WIDTH-1:0] BU_LAST     = D_WIDTH'(BU_PER_STAGE - 1);
    localparam logic [CNT_W-1:0]   INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic               inv_q,   inv_d;
    logic [D_WIDTH-1:0] depth_q, depth_d;
    logic [D_WIDTH-1:0] bu_q,    bu_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic               last_stage;

    // Stage that ends the transform depends on the direction latched at start.
    assign last_stage = inv_q ? (depth_q == STAGE_FIRST) : (depth_q == STAGE_LAST);

    // State and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            inv_q   <= 1'b0;
            depth_q <= '0;
            bu_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            inv_q   <= inv_d;
            depth_q <= depth_d;
            bu_q    <= bu_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter update; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        inv_d   = inv_q;
        depth_d = depth_q;
        bu_d    = bu_q;
        cnt_d   = cnt_q;

        if (bus.abort) begin
            state_d = S_IDLE;
            bu_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        inv_d   = bus.inv_mode;
                        cnt_d   = '0;
                        state_d = S_INIT;
                    end
                end
                S_INIT: begin
                    if (cnt_q == INIT_LAST) begin
                        cnt_d   = '0;
                        bu_d    = '0;
                        depth_d = inv_q ? STAGE_LAST : STAGE_FIRST;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    if (bus.agu_valid) begin
                        if (bu_q == BU_LAST) begin
                            bu_d    = '0;
                            cnt_d   = '0;
                            state_d = S_DRAIN;
                        end else begin
                            bu_d = bu_q + D_WIDTH'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (cnt_q == DRAIN_LAST) begin
                        cnt_d = '0;
                        if (last_stage) begin
                            state_d = S_DONE;
                        end else begin
                            depth_d = inv_q ? (depth_q - D_WIDTH'(1)) : (depth_q + D_WIDTH'(1));
                            state_d = S_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode.
    always_comb begin
        bus.tf_init_base  = 1'b0;
        bus.tf_init_const = 1'b0;
        bus.tf_ren        = 1'b0;
        bus.agu_enable    = 1'b0;
        bus.r_enable      = 1'b0;
        bus.w_enable      = 1'b0;
        bus.ntt_enable    = 1'b0;
        bus.done          = 1'b0;
        bus.busy          = (state_q != S_IDLE);
        bus.it_depth_cnt  = depth_q;
        bus.bu_idx        = bu_q;

        case (state_q)
            S_INIT: begin
                bus.tf_init_base  = 1'b1;
                bus.tf_init_const = 1'b1;
            end
            S_RUN: begin
                bus.agu_enable = 1'b1;
                bus.r_enable   = bus.agu_valid;
                bus.tf_ren     = bus.agu_valid;
                bus.ntt_enable = bus.rd_ack;
                bus.w_enable   = bus.ntt_done;
            end
            S_DRAIN: begin
                bus.ntt_enable = bus.rd_ack;
                bus.w_enable   = bus.ntt_done;
            end
            S_DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_ntt_stage_seq.sv
// Self-checking bench for ntt_stage_seq (3 stages, 4 butterflies, 3 init, 2 drain).
// Expected traces come from a phase-level model of the transform built per test.
module tb_ntt_stage_seq;

    localparam int NS  = 3;
    localparam int BU  = 4;
    localparam int INI = 3;
    localparam int DRN = 2;
    localparam int LEN = 512;

    logic clk;
    logic rst;

    ntt_stage_seq_if #(.D_WIDTH(8)) ifc ();

    ntt_stage_seq #(
        .D_WIDTH      (8),
        .NUM_STAGES   (NS),
        .BU_PER_STAGE (BU),
        .INIT_CYCLES  (INI),
        .DRAIN_CYCLES (DRN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    // Per-cycle stimulus and expected output records.
    bit          st [LEN];
    bit          ab [LEN];
    bit          rs [LEN];
    bit          av [LEN];
    bit          ra [LEN];
    bit          nd [LEN];
    logic [24:0] exp_a [LEN];
    int          model_depth;
    bit          inv_sel;

    // Record layout: {tf_init_base, tf_init_const, tf_ren, agu_enable, r_enable,
    //                 w_enable, ntt_enable, busy, done, it_depth_cnt, bu_idx}
    function automatic logic [24:0] mk(input logic [8:0] f, input int d, input int b);
        return {f, 8'(d), 8'(b)};
    endfunction

    function automatic logic [24:0] pack_obs();
        return {ifc.tf_init_base, ifc.tf_init_const, ifc.tf_ren, ifc.agu_enable,
                ifc.r_enable, ifc.w_enable, ifc.ntt_enable, ifc.busy, ifc.done,
                ifc.it_depth_cnt, ifc.bu_idx};
    endfunction

    // Transform model: start cycle, INIT, RUN/DRAIN per stage, DONE.
    // Returns the index of the first cycle after DONE.
    function automatic int model_transform(input int t0, input bit inv);
        int t;
        int cnt;
        int s;
        t = t0;
        exp_a[t] = mk(9'b0, model_depth, 0);
        t++;
        for (int i = 0; i < INI; i++) begin
            exp_a[t] = mk(9'b110000010, model_depth, 0);
            t++;
        end
        for (int k = 0; k < NS; k++) begin
            s = inv ? (NS - 1 - k) : k;
            model_depth = s;
            cnt = 0;
            while (cnt < BU && t < LEN - 40) begin
                exp_a[t] = mk({1'b0, 1'b0, av[t], 1'b1, av[t], nd[t], ra[t], 1'b1, 1'b0}, s, cnt);
                if (av[t]) cnt++;
                t++;
            end
            for (int i = 0; i < DRN; i++) begin
                exp_a[t] = mk({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, nd[t], ra[t], 1'b1, 1'b0}, s, 0);
                t++;
            end
        end
        exp_a[t] = mk(9'b000000011, model_depth, 0);
        t++;
        return t;
    endfunction

    task automatic clear_stim();
        for (int t = 0; t < LEN; t++) begin
            st[t] = 1'b0;
            ab[t] = 1'b0;
            rs[t] = 1'b1;
            av[t] = 1'b1;
            ra[t] = 1'($urandom);
            nd[t] = 1'($urandom);
        end
    endtask

    // Applies the stimulus of cycle t, samples at the falling edge, returns
    // one cycle later just after the rising edge.
    task automatic cycle_io(input int t, output logic [24:0] obs);
        ifc.start     = st[t];
        ifc.inv_mode  = inv_sel;
        ifc.abort     = ab[t];
        ifc.agu_valid = av[t];
        ifc.rd_ack    = ra[t];
        ifc.ntt_done  = nd[t];
        rst           = rs[t];
        @(negedge clk);
        obs = pack_obs();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] obs;
        clear_stim();
        inv_sel = 1'b1;
        for (int t = 0; t < 4; t++) begin
            rs[t] = 1'b0;
            st[t] = 1'b1;
        end
        for (int t = 0; t < 4; t++) begin
            cycle_io(t, obs);
            vectors++;
            if (obs !== 25'h0) begin
                miscompares++;
                $display("FAIL reset t=%0d got %h expected %h", t, obs, 25'h0);
            end
        end
        model_depth = 0;
    endtask

    task automatic test_forward();
        logic [24:0] obs;
        int n;
        clear_stim();
        inv_sel = 1'b0;
        st[0] = 1'b1;
        n = model_transform(0, 1'b0);
        exp_a[n] = mk(9'b0, model_depth, 0);
        for (int t = 0; t <= n; t++) begin
            cycle_io(t, obs);
            vectors++;
            if (obs !== exp_a[t]) begin
                miscompares++;
                $display("FAIL forward t=%0d got %h expected %h", t, obs, exp_a[t]);
            end
            vectors++;
            if (obs[16] !== (t == 1 + INI + NS * (BU + DRN))) begin
                miscompares++;
                $display("FAIL forward_done_time t=%0d done=%b", t, obs[16]);
            end
        end
    endtask

    task automatic test_inverse();
        logic [24:0] obs;
        int n;
        clear_stim();
        inv_sel = 1'b1;
        st[0] = 1'b1;
        n = model_transform(0, 1'b1);
        exp_a[n] = mk(9'b0, model_depth, 0);
        for (int t = 0; t <= n; t++) begin
            cycle_io(t, obs);
            vectors++;
            if (obs !== exp_a[t]) begin
                miscompares++;
                $display("FAIL inverse t=%0d got %h expected %h", t, obs, exp_a[t]);
            end
            vectors++;
            if (obs[16] !== (t == 1 + INI + NS * (BU + DRN))) begin
                miscompares++;
                $display("FAIL inverse_done_time t=%0d done=%b", t, obs[16]);
            end
        end
    endtask

    task automatic test_gapped();
        logic [24:0] obs;
        int n;
        clear_stim();
        inv_sel = 1'b0;
        st[0] = 1'b1;
        for (int t = 0; t < LEN; t++) av[t] = (t % 2 == 1);
        n = model_transform(0, 1'b0);
        exp_a[n] = mk(9'b0, model_depth, 0);
        for (int t = 0; t <= n; t++) begin
            cycle_io(t, obs);
            vectors++;
            if (obs !== exp_a[t]) begin
                miscompares++;
                $display("FAIL gapped t=%0d got %h expected %h", t, obs, exp_a[t]);
            end
            vectors++;
            if (obs[16] !== (t == 1 + INI + NS * (2 * BU + DRN))) begin
                miscompares++;
                $display("FAIL gapped_done_time t=%0d done=%b", t, obs[16]);
            end
        end
    endtask

    task automatic test_random();
        logic [24:0] obs;
        int n;
        for (int r = 0; r < 4; r++) begin
            clear_stim();
            inv_sel = 1'($urandom);
            st[0] = 1'b1;
            for (int t = 0; t < 300; t++) av[t] = 1'($urandom);
            n = model_transform(0, inv_sel);
            exp_a[n] = mk(9'b0, model_depth, 0);
            for (int t = 0; t <= n; t++) begin
                cycle_io(t, obs);
                vectors++;
                if (obs !== exp_a[t]) begin
                    miscompares++;
                    $display("FAIL random r=%0d t=%0d got %h expected %h", r, t, obs, exp_a[t]);
                end
            end
        end
    endtask

    task automatic test_abort();
        logic [24:0] obs;
        int n;
        int t_ab;
        clear_stim();
        inv_sel = 1'b0;
        st[0] = 1'b1;
        // Stage 1 RUN begins after start, INIT and stage 0; bu_idx=2 two cycles in.
        t_ab = 1 + INI + (BU + DRN) + 2;
        ab[t_ab] = 1'b1;
        st[t_ab] = 1'b1;
        n = model_transform(0, 1'b0);
        for (int t = t_ab + 1; t < t_ab + 4; t++) exp_a[t] = mk(9'b0, 1, 0);
        model_depth = 1;
        st[t_ab + 4] = 1'b1;
        n = model_transform(t_ab + 4, 1'b0);
        exp_a[n] = mk(9'b0, model_depth, 0);
        for (int t = 0; t <= n; t++) begin
            cycle_io(t, obs);
            vectors++;
            if (obs !== exp_a[t]) begin
                miscompares++;
                $display("FAIL abort t=%0d got %h expected %h", t, obs, exp_a[t]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [24:0] obs;
        int n;
        int t_rs;
        clear_stim();
        inv_sel = 1'b1;
        st[0] = 1'b1;
        n = model_transform(0, 1'b1);
        // First DRAIN cycle of stage NS-1 (the first inverse stage).
        t_rs = 1 + INI + BU;
        rs[t_rs] = 1'b0;
        exp_a[t_rs] = 25'h0;
        model_depth = 0;
        inv_sel = 1'b0;
        st[t_rs + 1] = 1'b1;
        for (int t = t_rs + 1; t < LEN; t++) av[t] = 1'b1;
        n = model_transform(t_rs + 1, 1'b0);
        exp_a[n] = mk(9'b0, model_depth, 0);
        for (int t = 0; t <= n; t++) begin
            // inv_mode flips after reset so the restart runs forward.
            if (t == t_rs + 1) inv_sel = 1'b0;
            else if (t == 0) inv_sel = 1'b1;
            cycle_io(t, obs);
            vectors++;
            if (obs !== exp_a[t]) begin
                miscompares++;
                $display("FAIL reset_mid t=%0d got %h expected %h", t, obs, exp_a[t]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [24:0] obs;
        int n1;
        int n2;
        clear_stim();
        inv_sel = 1'b0;
        n1 = model_transform(0, 1'b0);
        for (int t = 0; t <= n1; t++) st[t] = 1'b1;
        n2 = model_transform(n1, 1'b0);
        exp_a[n2] = mk(9'b0, model_depth, 0);
        for (int t = 0; t <= n2; t++) begin
            cycle_io(t, obs);
            vectors++;
            if (obs !== exp_a[t]) begin
                miscompares++;
                $display("FAIL back_to_back t=%0d got %h expected %h", t, obs, exp_a[t]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_depth = 0;
        inv_sel     = 1'b0;
        rst           = 1'b0;
        ifc.start     = 1'b0;
        ifc.inv_mode  = 1'b0;
        ifc.abort     = 1'b0;
        ifc.agu_valid = 1'b0;
        ifc.rd_ack    = 1'b0;
        ifc.ntt_done  = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_forward();
        test_inverse();
        test_gapped();
        test_random();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
